// File: rtl/vga_console_seq.sv
// vga_console_seq: byte-stream text console that writes glyphs/attributes into the VGA char and color maps
module vga_console_seq #(
    parameter logic [31:0] BASE_ADDR   = 32'h0700_0000,
    parameter int          COLS        = 80,
    parameter int          ROWS        = 30,
    parameter logic [7:0]  BLANK_COLOR = 8'h0F
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        ch_valid_i,
    input  logic [7:0]  ch_data_i,
    input  logic [7:0]  color_i,
    output logic        ch_ready_o,
    input  logic        clear_i,
    output logic        busy_o,
    output logic [6:0]  cursor_col_o,
    output logic [4:0]  cursor_row_o,
    output logic        req_o,
    output logic        write_enable_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] addr_o,
    output logic [31:0] write_data_o,
    input  logic        stall_i
);
    typedef enum logic [2:0] {IDLE, WR_CHAR, WR_COL, CLR_CHAR, CLR_COL} state_t;

    localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);
    localparam logic [11:0] COLS_W      = 12'(COLS);
    localparam logic [9:0]  LINE_LAST   = 10'(COLS / 4 - 1);
    localparam logic [9:0]  SCREEN_LAST = 10'(ROWS * COLS / 4 - 1);
    localparam logic [31:0] COLOR_OFF   = 32'h0000_1000;
    localparam logic [31:0] SPACES      = 32'h2020_2020;

    state_t      state_q;
    logic        clr_pend_q, full_q, req_q;
    logic [6:0]  col_q;
    logic [4:0]  row_q;
    logic [7:0]  color_q;
    logic [9:0]  wcnt_q;
    logic [3:0]  be_q;
    logic [31:0] addr_q, data_q;

    logic [4:0]  row_nl_d;
    logic [11:0] off_d, line_off_d;
    logic        printable_d;

    assign row_nl_d     = (row_q == ROW_LAST) ? 5'd0 : row_q + 5'd1;
    assign off_d        = 12'(row_q) * COLS_W + 12'(col_q);
    assign line_off_d   = 12'(row_nl_d) * COLS_W;
    assign printable_d  = (ch_data_i >= 8'h20) && (ch_data_i <= 8'h7E);

    assign ch_ready_o     = (state_q == IDLE) && !clr_pend_q && !clear_i;
    assign busy_o         = (state_q != IDLE) || clr_pend_q;
    assign cursor_col_o   = col_q;
    assign cursor_row_o   = row_q;
    assign req_o          = req_q;
    assign write_enable_o = req_q;
    assign mem_be_o       = be_q;
    assign addr_o         = addr_q;
    assign write_data_o   = data_q;

    // Sequencer FSM; every bus output is loaded on the edge that enters its state and held while stalled
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            clr_pend_q <= 1'b0;
            full_q     <= 1'b0;
            col_q      <= '0;
            row_q      <= '0;
            color_q    <= '0;
            wcnt_q     <= '0;
            req_q      <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            if (clear_i && state_q != IDLE)
                clr_pend_q <= 1'b1;
            case (state_q)
                IDLE: begin
                    if (clear_i || clr_pend_q) begin
                        clr_pend_q <= 1'b0;
                        col_q      <= '0;
                        row_q      <= '0;
                        full_q     <= 1'b1;
                        wcnt_q     <= '0;
                        state_q    <= CLR_CHAR;
                        req_q      <= 1'b1;
                        addr_q     <= BASE_ADDR;
                        be_q       <= 4'hF;
                        data_q     <= SPACES;
                    end else if (ch_valid_i) begin
                        color_q <= color_i;
                        if (printable_d) begin
                            state_q <= WR_CHAR;
                            req_q   <= 1'b1;
                            addr_q  <= BASE_ADDR + {20'd0, off_d};
                            be_q    <= 4'b0001 << off_d[1:0];
                            data_q  <= {4{ch_data_i}};
                        end else if (ch_data_i == 8'h0A) begin
                            col_q   <= '0;
                            row_q   <= row_nl_d;
                            full_q  <= 1'b0;
                            wcnt_q  <= '0;
                            state_q <= CLR_CHAR;
                            req_q   <= 1'b1;
                            addr_q  <= BASE_ADDR + {20'd0, line_off_d};
                            be_q    <= 4'hF;
                            data_q  <= SPACES;
                        end else if (ch_data_i == 8'h0D) begin
                            col_q <= '0;
                        end else if (ch_data_i == 8'h08 && col_q != 7'd0) begin
                            col_q <= col_q - 7'd1;
                        end
                    end
                end
                WR_CHAR: if (!stall_i) begin
                    state_q <= WR_COL;
                    addr_q  <= addr_q + COLOR_OFF;
                    data_q  <= {4{color_q}};
                end
                WR_COL: if (!stall_i) begin
                    if (col_q == COL_LAST) begin
                        col_q   <= '0;
                        row_q   <= row_nl_d;
                        full_q  <= 1'b0;
                        wcnt_q  <= '0;
                        state_q <= CLR_CHAR;
                        addr_q  <= BASE_ADDR + {20'd0, line_off_d};
                        be_q    <= 4'hF;
                        data_q  <= SPACES;
                    end else begin
                        col_q   <= col_q + 7'd1;
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end
                end
                CLR_CHAR: if (!stall_i) begin
                    state_q <= CLR_COL;
                    addr_q  <= addr_q + COLOR_OFF;
                    data_q  <= {4{BLANK_COLOR}};
                end
                CLR_COL: if (!stall_i) begin
                    if (wcnt_q == (full_q ? SCREEN_LAST : LINE_LAST)) begin
                        state_q <= IDLE;
                        req_q   <= 1'b0;
                    end else begin
                        wcnt_q  <= wcnt_q + 10'd1;
                        state_q <= CLR_CHAR;
                        addr_q  <= addr_q - COLOR_OFF + 32'd4;
                        data_q  <= SPACES;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vga_console_seq.sv
// tb_vga_console_seq: directed checks of printing, stalls, newline clears, screen clears and reset
module tb_vga_console_seq;
    logic        clk_i = 1'b0, rst_i = 1'b1;
    logic        ch_valid_i = 1'b0, clear_i = 1'b0, stall_i = 1'b0;
    logic [7:0]  ch_data_i = 8'h00, color_i = 8'h00;
    logic        ch_ready_o, busy_o, req_o, write_enable_o;
    logic [6:0]  cursor_col_o;
    logic [4:0]  cursor_row_o;
    logic [3:0]  mem_be_o;
    logic [31:0] addr_o, write_data_o;

    int n_tests = 0, n_fail = 0;
    int nw = 0, nchr = 0, ncol = 0, ready_seen = 0;
    int w0, c0, k0;
    logic [31:0] last_addr = '0, last_data = '0;

    vga_console_seq dut (
        .clk_i(clk_i), .rst_i(rst_i), .ch_valid_i(ch_valid_i), .ch_data_i(ch_data_i),
        .color_i(color_i), .ch_ready_o(ch_ready_o), .clear_i(clear_i), .busy_o(busy_o),
        .cursor_col_o(cursor_col_o), .cursor_row_o(cursor_row_o), .req_o(req_o),
        .write_enable_o(write_enable_o), .mem_be_o(mem_be_o), .addr_o(addr_o),
        .write_data_o(write_data_o), .stall_i(stall_i)
    );

    always #5 clk_i = ~clk_i;

    // Bus-side monitor: tallies completed writes split by char/color map
    always @(posedge clk_i) begin
        if (!rst_i && req_o && !stall_i) begin
            nw++;
            if (addr_o[12]) ncol++; else nchr++;
            last_addr = addr_o;
            last_data = write_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic [7:0] c, input logic [7:0] a);
        int t = 0;
        @(negedge clk_i);
        while (!ch_ready_o && t < 5000) begin
            @(negedge clk_i);
            t++;
        end
        if (t >= 5000) check("send_timeout", 32'(t), 32'd0);
        ch_valid_i = 1'b1;
        ch_data_i  = c;
        color_i    = a;
        @(negedge clk_i);
        ch_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy_o && t < 3000) begin
            if (ch_ready_o) ready_seen++;
            @(negedge clk_i);
            t++;
        end
        if (t >= 3000) check("idle_timeout", 32'(t), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_req", 32'(req_o), 32'd0);
        check("rst_we", 32'(write_enable_o), 32'd0);
        check("rst_be", 32'(mem_be_o), 32'd0);
        check("rst_addr", addr_o, 32'd0);
        check("rst_data", write_data_o, 32'd0);
        check("rst_ready", 32'(ch_ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_cursor", {20'd0, cursor_row_o, cursor_col_o}, 32'd0);
        rst_i = 1'b0;

        send(8'h41, 8'h1E);
        check("a_req", 32'(req_o), 32'd1);
        check("a_we", 32'(write_enable_o), 32'd1);
        check("a_addr", addr_o, 32'h0700_0000);
        check("a_be", 32'(mem_be_o), 32'h1);
        check("a_data", write_data_o, 32'h4141_4141);
        check("a_ready_busy", 32'(ch_ready_o), 32'd0);
        @(negedge clk_i);
        check("a_col_addr", addr_o, 32'h0700_1000);
        check("a_col_data", write_data_o, 32'h1E1E_1E1E);
        @(negedge clk_i);
        check("a_req_done", 32'(req_o), 32'd0);
        check("a_ready_again", 32'(ch_ready_o), 32'd1);
        check("a_cursor", {20'd0, cursor_row_o, cursor_col_o}, 32'd1);

        send(8'h62, 8'h07);
        send(8'h63, 8'h07);
        wait_idle();
        check("col3", 32'(cursor_col_o), 32'd3);
        w0 = nchr; c0 = ncol;
        stall_i = 1'b1;
        send(8'h42, 8'h2A);
        for (int i = 0; i < 4; i++) begin
            check("stall_addr", addr_o, 32'h0700_0003);
            check("stall_be", 32'(mem_be_o), 32'h8);
            check("stall_req", 32'(req_o), 32'd1);
            @(negedge clk_i);
        end
        stall_i = 1'b0;
        wait_idle();
        check("stall_chr_writes", 32'(nchr - w0), 32'd1);
        check("stall_col_writes", 32'(ncol - c0), 32'd1);
        check("stall_last_data", last_data, 32'h2A2A_2A2A);
        check("stall_cursor", {20'd0, cursor_row_o, cursor_col_o}, 32'd4);

        for (int i = 0; i < 5; i++) send(8'h0A, 8'h00);
        wait_idle();
        check("lf5_cursor", {20'd0, cursor_row_o, cursor_col_o}, {20'd0, 5'd5, 7'd0});
        w0 = nw;
        for (int i = 0; i < 80; i++) send(8'h30 + 8'(i % 10), 8'h1F);
        wait_idle();
        check("wrap_cursor", {20'd0, cursor_row_o, cursor_col_o}, {20'd0, 5'd6, 7'd0});
        check("wrap_writes", 32'(nw - w0), 32'd200);
        check("wrap_last_addr", last_addr, 32'h0700_122C);
        check("wrap_last_data", last_data, 32'h0F0F_0F0F);

        for (int i = 0; i < 17; i++) send(8'h61, 8'h1F);
        wait_idle();
        check("col17", 32'(cursor_col_o), 32'd17);
        w0 = nw;
        send(8'h0D, 8'h00);
        check("cr_req", 32'(req_o), 32'd0);
        @(negedge clk_i);
        check("cr_cursor", {20'd0, cursor_row_o, cursor_col_o}, {20'd0, 5'd6, 7'd0});
        send(8'h08, 8'h00);
        @(negedge clk_i);
        check("bs0_cursor", {20'd0, cursor_row_o, cursor_col_o}, {20'd0, 5'd6, 7'd0});
        check("cr_bs_writes", 32'(nw - w0), 32'd0);
        send(8'h61, 8'h1F);
        send(8'h61, 8'h1F);
        wait_idle();
        send(8'h08, 8'h00);
        @(negedge clk_i);
        check("bs_cursor", 32'(cursor_col_o), 32'd1);
        send(8'h01, 8'h00);
        @(negedge clk_i);
        check("other_code", {20'd0, cursor_row_o, cursor_col_o}, {20'd0, 5'd6, 7'd1});
        check("other_busy", 32'(busy_o), 32'd0);

        for (int i = 0; i < 23; i++) send(8'h0A, 8'h00);
        wait_idle();
        check("row29", {20'd0, cursor_row_o, cursor_col_o}, {20'd0, 5'd29, 7'd0});
        w0 = nchr; c0 = ncol;
        send(8'h0A, 8'h00);
        check("lf_wrap_cursor", {20'd0, cursor_row_o, cursor_col_o}, 32'd0);
        check("lf_first_addr", addr_o, 32'h0700_0000);
        check("lf_first_data", write_data_o, 32'h2020_2020);
        check("lf_first_be", 32'(mem_be_o), 32'hF);
        wait_idle();
        check("lf_chr_writes", 32'(nchr - w0), 32'd20);
        check("lf_col_writes", 32'(ncol - c0), 32'd20);
        check("lf_last_addr", last_addr, 32'h0700_104C);
        check("lf_last_data", last_data, 32'h0F0F_0F0F);

        w0 = nw;
        send(8'h0A, 8'h00);
        repeat (3) @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("pend_busy", 32'(busy_o), 32'd1);
        check("pend_ready", 32'(ch_ready_o), 32'd0);
        ready_seen = 0;
        wait_idle();
        check("pend_ready_seen", 32'(ready_seen), 32'd0);
        check("pend_writes", 32'(nw - w0), 32'd1240);
        check("pend_cursor", {20'd0, cursor_row_o, cursor_col_o}, 32'd0);
        check("pend_last_addr", last_addr, 32'h0700_195C);

        send(8'h41, 8'h1E);
        wait_idle();
        w0 = nw; k0 = nchr;
        @(negedge clk_i);
        clear_i = 1'b1;
        ch_valid_i = 1'b1;
        ch_data_i = 8'h5A;
        #1 check("clr_vs_valid_ready", 32'(ch_ready_o), 32'd0);
        @(negedge clk_i);
        clear_i = 1'b0;
        ch_valid_i = 1'b0;
        check("clr_home", {20'd0, cursor_row_o, cursor_col_o}, 32'd0);
        check("clr_busy", 32'(busy_o), 32'd1);
        wait_idle();
        check("clr_writes", 32'(nw - w0), 32'd1200);
        check("clr_chr_writes", 32'(nchr - k0), 32'd600);

        @(negedge clk_i);
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        repeat (50) @(negedge clk_i);
        check("midclr_req", 32'(req_o), 32'd1);
        #2 rst_i = 1'b1;
        #1 check("async_rst_req", 32'(req_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        w0 = nw;
        repeat (20) @(negedge clk_i);
        check("post_rst_writes", 32'(nw - w0), 32'd0);
        check("post_rst_ready", 32'(ch_ready_o), 32'd1);
        check("post_rst_busy", 32'(busy_o), 32'd0);
        check("post_rst_cursor", {20'd0, cursor_row_o, cursor_col_o}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
